decode_bundle_stager: RTL
=========================

Name: decode_bundle_stager

Overview:
- Transmit-side staging queue between the Decode stage and the instruction buffer.
- Accepts one decoded bundle per cycle from Decode: up to 2*FETCH_BANDWIDTH packets plus a slot-valid vector.
- Holds each bundle and presents it to the instruction buffer with decodeReady/decodedVector qualifiers.
- Holds the bundle stable while the buffer asserts stallFetch, so Decode can run one bundle ahead of buffer back-pressure without losing instructions.

Parameters:
FETCH_BANDWIDTH, 4, packets per fetch group; a bundle has NSLOT = 2*FETCH_BANDWIDTH slots.
PACKET_WIDTH, 128, bits per decoded packet; must equal the instruction-buffer packet width.
DEPTH, 2, bundle entries; power of two, minimum 2.
DEPTH_LOG, 1, log2(DEPTH).

Ports:
clk  input  1  core clock, rising edge.
reset  input  1  reset, asynchronous, active-low.
flush_i  input  1  control-misprediction flush, synchronous.
bundleValid_i  input  1  Decode offers a bundle this cycle.
bundleVector_i  input  NSLOT  per-slot valid bits of the offered bundle.
bundlePackets_i  input  NSLOT*PACKET_WIDTH  slot k occupies bits [k*PACKET_WIDTH +: PACKET_WIDTH].
bundleReady_o  output  1  stager can accept a bundle this cycle.
stallFetch_i  input  1  instruction buffer cannot accept a bundle.
decodeReady_o  output  1  head bundle is valid and presented.
decodedVector_o  output  NSLOT  head bundle slot-valid bits.
decodedPackets_o  output  NSLOT*PACKET_WIDTH  head bundle packets, same slot layout as input.
occupancy_o  output  DEPTH_LOG+1  bundles currently held.

Behaviour:
- Storage: circular queue of DEPTH entries, each holding {vector, packets}.
  - headPtr and tailPtr are DEPTH_LOG bits and wrap modulo DEPTH.
  - count is DEPTH_LOG+1 bits.
- Reset (reset low, asynchronous):
  - headPtr, tailPtr and count go to 0.
  - decodeReady_o=0, decodedVector_o=0, occupancy_o=0, bundleReady_o=1.
  - Packet storage is not required to reset.
- bundleReady_o = (count != DEPTH). Purely state-derived; no combinational path from stallFetch_i.
- Push:
  - Condition: push = bundleValid_i & bundleReady_o & (|bundleVector_i) & ~flush_i.
  - On push, the entry at tailPtr is written and tailPtr increments.
  - An all-zero vector is consumed (handshake completes) but not stored.
- Present: decodeReady_o = (count != 0). decodedVector_o and decodedPackets_o come from the entry at headPtr.
  - When count == 0, decodedVector_o is forced to 0 and decodedPackets_o is don't-care.
- Pop:
  - Condition: pop = decodeReady_o & ~stallFetch_i & ~flush_i.
  - This matches the buffer's write rule (decodeReady & vector & ~stallFetch).
  - On pop, headPtr increments.
- Stability: while decodeReady_o=1 and stallFetch_i=1, decodedVector_o and decodedPackets_o hold unchanged every cycle.
- Latency: a bundle pushed in cycle t is visible on the outputs in cycle t+1 at the earliest.
- count next state:
  - push & pop: count unchanged.
  - push only: count+1.
  - pop only: count-1.
- Full with simultaneous pop: bundleReady_o is still 0 that cycle, so there is no push. The next cycle shows count = DEPTH-1 and ready = 1.
- Flush: in the next cycle, count, headPtr and tailPtr become 0 and decodeReady_o = 0. Flush has priority over push and pop in the same cycle.
- Reset mid-operation: all held bundles are discarded immediately. There is no partial-bundle state.
- occupancy_o = count, registered.
- Assertions (simulation only): no push when count == DEPTH; no pop when count == 0.

Optional Feature:
- Macro: DECODE_STAGER_BYPASS_EN.
- Defined:
  - When count == 0, bundleValid_i=1, bundleVector_i nonzero, stallFetch_i=0 and flush_i=0, the input bundle drives decodeReady_o/decodedVector_o/decodedPackets_o combinationally in the same cycle.
  - That bundle is not stored and the pointers do not move. Zero-cycle latency.
  - If stallFetch_i=1 in that cycle, the bundle is pushed normally instead.
- Not defined: minimum latency is 1 cycle; outputs depend only on registered state.

Test Plan:
- Reset low mid-run with count=2 -> same cycle: decodeReady_o=0, occupancy_o=0, bundleReady_o=1; the entries are never presented after reset release.
- Push bundle vector=8'h0F, packets slot0..3 = 1..4 with stallFetch_i=0 -> cycle t+1: decodeReady_o=1, vector 8'h0F, slot0=1; cycle t+2: occupancy_o=0.
- stallFetch_i=1 for 5 cycles while pushing 3 bundles A, B, C -> A and B accepted, bundleReady_o=0 after B, outputs hold A unchanged for all 5 cycles; release -> A, B, then C delivered in order.
- Push with bundleVector_i=0 -> bundleReady_o stays 1, occupancy_o stays 0, decodeReady_o stays 0.
- flush_i=1 with count=2 and a simultaneous push -> next cycle occupancy_o=0, decodeReady_o=0, pushed bundle dropped.
- DECODE_STAGER_BYPASS_EN defined, empty queue, push vector=8'hFF, stallFetch_i=0 -> same cycle decodeReady_o=1, decodedVector_o=8'hFF, occupancy_o stays 0.

Source files
------------

// File: rtl/decode_bundle_stager.sv
// Decode-to-instruction-buffer bundle staging queue. Latency is 1 cycle by default, or 0 when the queue is empty and DECODE_STAGER_BYPASS_EN is defined.
// bundleReady_o depends only on the fill count. The head bundle holds while stallFetch_i is high.
module decode_bundle_stager #(
  parameter int FETCH_BANDWIDTH = 4,
  parameter int PACKET_WIDTH    = 128,
  parameter int DEPTH           = 2,
  parameter int DEPTH_LOG       = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush_i,
  input  logic                                      bundleValid_i,
  input  logic [2*FETCH_BANDWIDTH-1:0]              bundleVector_i,
  input  logic [2*FETCH_BANDWIDTH*PACKET_WIDTH-1:0] bundlePackets_i,
  output logic                                      bundleReady_o,
  input  logic                                      stallFetch_i,
  output logic                                      decodeReady_o,
  output logic [2*FETCH_BANDWIDTH-1:0]              decodedVector_o,
  output logic [2*FETCH_BANDWIDTH*PACKET_WIDTH-1:0] decodedPackets_o,
  output logic [DEPTH_LOG:0]                        occupancy_o
);

  localparam int NSLOT = 2 * FETCH_BANDWIDTH;
  localparam int BW    = NSLOT * PACKET_WIDTH;
  localparam logic [DEPTH_LOG:0]   FULL    = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0]   CNT_ONE = (DEPTH_LOG+1)'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE = DEPTH_LOG'(1);

  logic [NSLOT-1:0]     vec_q [DEPTH];
  logic [BW-1:0]        pkt_q [DEPTH];
  logic [DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 q_valid, push, pop, bypass;

  assign q_valid       = (count_q != '0);
  assign bundleReady_o = (count_q != FULL);
  assign occupancy_o   = count_q;

`ifdef DECODE_STAGER_BYPASS_EN
  assign bypass = ~q_valid & bundleValid_i & (|bundleVector_i) & ~stallFetch_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  // All-zero bundles complete the handshake but are never stored.
  assign push = bundleValid_i & bundleReady_o & (|bundleVector_i) & ~flush_i & ~bypass;
  assign pop  = q_valid & ~stallFetch_i & ~flush_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_ONE;
      if (pop)  head_d = head_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; count_q gates everything read from it.
  always_ff @(posedge clk) begin
    if (push) begin
      vec_q[tail_q] <= bundleVector_i;
      pkt_q[tail_q] <= bundlePackets_i;
    end
  end

  always_comb begin
    decodeReady_o    = q_valid;
    decodedVector_o  = q_valid ? vec_q[head_q] : '0;
    decodedPackets_o = pkt_q[head_q];
    if (bypass) begin
      decodeReady_o    = 1'b1;
      decodedVector_o  = bundleVector_i;
      decodedPackets_o = bundlePackets_i;
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (!reset) push |-> (count_q != FULL));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset) pop |-> (count_q != '0));
`endif

endmodule
